// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: FWFT character FIFO with parity flags,
// watermark-driven rts_n flow control, sticky overrun and a saturating parity-error count.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned HI_WM = 12,
    parameter int unsigned LO_WM = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_done,
    input  logic [7:0]    rx_data,
    input  logic          parity_error,
    input  logic          flush,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_perr,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overrun,
    input  logic          overrun_clr,
    output logic [7:0]    perr_cnt,
    output logic          rts_n
);

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    perr_cnt_q, perr_cnt_d;
    logic          rts_n_q, rts_n_d;
    logic          pop_ok, push_ok, drop;
    logic [8:0]    head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A pop frees a slot in the same cycle, so a full buffer can still accept a push.
    assign pop_ok  = rd_en && !empty && !flush;
    assign push_ok = rx_done && !flush && (!full || pop_ok);
    assign drop    = rx_done && !flush && full && !pop_ok;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overrun_d  = overrun_q;
        perr_cnt_d = perr_cnt_q;
        rts_n_d    = rts_n_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        if (push_ok && parity_error && (perr_cnt_q != 8'hff)) begin
            perr_cnt_d = perr_cnt_q + 8'd1;
        end

        // Hysteresis from the registered count: lags the fill level by one edge.
        if (count_q >= CW'(HI_WM)) begin
            rts_n_d = 1'b1;
        end else if (count_q <= CW'(LO_WM)) begin
            rts_n_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            perr_cnt_q <= 8'd0;
            rts_n_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            perr_cnt_q <= perr_cnt_d;
            rts_n_q    <= rts_n_d;
        end
    end

    // Storage needs no reset; contents are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {parity_error, rx_data};
    end

    assign head     = mem_q[rd_ptr_q];
    assign rd_data  = empty ? 8'h00 : head[7:0];
    assign rd_perr  = empty ? 1'b0 : head[8];
    assign count    = count_q;
    assign overrun  = overrun_q;
    assign perr_cnt = perr_cnt_q;
    assign rts_n    = rts_n_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table plus hand-written multi-cycle sequences,
// with a queue model checking every output after every edge.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int HI_WM = 12;
    localparam int LO_WM = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_done, parity_error, flush, rd_en, overrun_clr;
    logic [7:0] rx_data;
    logic [7:0] rd_data;
    logic       rd_perr, empty, full, overrun, rts_n;
    logic [4:0] count;
    logic [7:0] perr_cnt;

    uart_rx_fifo #(.DEPTH(DEPTH), .HI_WM(HI_WM), .LO_WM(LO_WM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_done      (rx_done),
        .rx_data      (rx_data),
        .parity_error (parity_error),
        .flush        (flush),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_perr      (rd_perr),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .perr_cnt     (perr_cnt),
        .rts_n        (rts_n)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [8:0] mq[$];
    logic       m_ovr;
    logic       m_rts;
    logic [7:0] m_pc;

    typedef struct {
        logic       rx;
        logic [7:0] d;
        logic       pe;
        logic       rd;
        logic [4:0] e_count;
        logic [7:0] e_data;
        logic       e_perr;
        logic [7:0] e_pc;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [8:0] h;
        h = (mq.size() > 0) ? mq[0] : 9'h000;
        check({tag, ".count"},    32'(count),    32'(mq.size()));
        check({tag, ".empty"},    32'(empty),    32'(mq.size() == 0));
        check({tag, ".full"},     32'(full),     32'(mq.size() == DEPTH));
        check({tag, ".rd_data"},  32'(rd_data),  32'(h[7:0]));
        check({tag, ".rd_perr"},  32'(rd_perr),  32'(h[8]));
        check({tag, ".overrun"},  32'(overrun),  32'(m_ovr));
        check({tag, ".perr_cnt"}, 32'(perr_cnt), 32'(m_pc));
        check({tag, ".rts_n"},    32'(rts_n),    32'(m_rts));
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr = 1'b0;
        m_rts = 1'b0;
        m_pc  = 8'd0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check just after it.
    task automatic step(input logic i_rx, input logic [7:0] i_d, input logic i_pe,
                        input logic i_rd, input logic i_fl, input logic i_clr);
        int  sz;
        logic pop, push;
        rx_done = i_rx; rx_data = i_d; parity_error = i_pe;
        rd_en = i_rd; flush = i_fl; overrun_clr = i_clr;
        @(posedge clk);
        sz   = mq.size();
        pop  = i_rd && (sz > 0);
        push = i_rx && ((sz < DEPTH) || pop);
        if (sz >= HI_WM) m_rts = 1'b1;
        else if (sz <= LO_WM) m_rts = 1'b0;
        if (i_fl) begin
            mq.delete();
            if (i_clr) m_ovr = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({i_pe, i_d});
                if (i_pe && m_pc != 8'hff) m_pc = m_pc + 8'd1;
            end
            if (i_rx && !push) m_ovr = 1'b1;
            else if (i_clr) m_ovr = 1'b0;
        end
        #1;
        rx_done = 1'b0; rd_en = 1'b0; flush = 1'b0; overrun_clr = 1'b0; parity_error = 1'b0;
        check_model("step");
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 5'd1, 8'h41, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 8'h42, 1'b1, 1'b0, 5'd2, 8'h41, 1'b0, 8'd1};
        tbl[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 5'd3, 8'h41, 1'b0, 8'd1};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd2, 8'h42, 1'b1, 8'd1};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 8'h43, 1'b0, 8'd1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'h00, 1'b0, 8'd1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'h00, 1'b0, 8'd1};
        tbl[7] = '{1'b1, 8'h50, 1'b1, 1'b1, 5'd1, 8'h50, 1'b1, 8'd2};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'h00, 1'b0, 8'd2};

        rst_n = 1'b0;
        rx_done = 1'b0; rx_data = 8'h00; parity_error = 1'b0;
        flush = 1'b0; rd_en = 1'b0; overrun_clr = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
        check_model("reset");

        // Basic push/pop, underflow, simultaneous push+pop on empty.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].rx, tbl[i].d, tbl[i].pe, tbl[i].rd, 1'b0, 1'b0);
            check($sformatf("tbl%0d.count", i),   32'(count),    32'(tbl[i].e_count));
            check($sformatf("tbl%0d.empty", i),   32'(empty),    32'(tbl[i].e_count == 0));
            check($sformatf("tbl%0d.rd_data", i), 32'(rd_data),  32'(tbl[i].e_data));
            check($sformatf("tbl%0d.rd_perr", i), 32'(rd_perr),  32'(tbl[i].e_perr));
            check($sformatf("tbl%0d.perr", i),    32'(perr_cnt), 32'(tbl[i].e_pc));
        end

        // Fill to full, overrun and its clear, drop vs clear priority.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("full.count", 32'(count), 32'd16);
        check("full.full", 32'(full), 32'd1);
        check("full.rts_n", 32'(rts_n), 32'd1);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        check("drop.overrun", 32'(overrun), 32'd1);
        check("drop.count", 32'(count), 32'd16);
        check("drop.head", 32'(rd_data), 32'h60);
        check("drop.perr", 32'(perr_cnt), 32'd2);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_clr.overrun", 32'(overrun), 32'd0);
        step(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b1);
        check("drop_and_clr.overrun", 32'(overrun), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_clr2.overrun", 32'(overrun), 32'd0);

        // Push+pop while full, then drain: 0x55 comes out last after the wrap.
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        check("fullrw.count", 32'(count), 32'd16);
        check("fullrw.overrun", 32'(overrun), 32'd0);
        check("fullrw.head", 32'(rd_data), 32'h61);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain%0d.head", i), 32'(rd_data),
                  (i < DEPTH - 1) ? 32'(8'h61 + i) : 32'h55);
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("drained.empty", 32'(empty), 32'd1);

        // Watermarks: rts_n rises one edge after count hits 12, falls one edge after 4.
        for (int i = 0; i < 12; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("wm12.rts_n", 32'(rts_n), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wm12_lag.rts_n", 32'(rts_n), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wm5.count", 32'(count), 32'd5);
        check("wm5.rts_n", 32'(rts_n), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wm4.rts_n", 32'(rts_n), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wm4_lag.rts_n", 32'(rts_n), 32'd0);

        // Flush with a same-cycle push: nothing stored, status untouched.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("preflush.count", 32'(count), 32'd8);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0);
        check("flush.count", 32'(count), 32'd0);
        check("flush.empty", 32'(empty), 32'd1);
        check("flush.rd_data", 32'(rd_data), 32'h00);
        check("flush.perr", 32'(perr_cnt), 32'd2);
        check("flush.overrun", 32'(overrun), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("postflush.rts_n", 32'(rts_n), 32'd0);

        // Asynchronous reset between edges with rts_n high and perr_cnt non-zero.
        for (int i = 0; i < 14; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("prerst.rts_n", 32'(rts_n), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.count", 32'(count), 32'd0);
        check("rst.empty", 32'(empty), 32'd1);
        check("rst.full", 32'(full), 32'd0);
        check("rst.rd_data", 32'(rd_data), 32'h00);
        check("rst.rd_perr", 32'(rd_perr), 32'd0);
        check("rst.overrun", 32'(overrun), 32'd0);
        check("rst.perr", 32'(perr_cnt), 32'd0);
        check("rst.rts_n", 32'(rts_n), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;

        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        check("afterrst.rd_data", 32'(rd_data), 32'h10);
        check("afterrst.count", 32'(count), 32'd1);

        // Long push+pop run: pointers wrap many times, perr_cnt saturates.
        for (int i = 0; i < 260; i++) step(1'b1, 8'(i) ^ 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
        check("wrap.count", 32'(count), 32'd1);
        check("wrap.head", 32'(rd_data), 32'(8'(259) ^ 8'h3C));
        check("sat.perr", 32'(perr_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
